// File: rtl/intt_final_scale.sv
// INTT output stage: multiplies each streamed coefficient by N^-1 mod Q.
// Three-stage stallable valid/ready pipeline with frame index tracking and a sticky range flag.
module intt_final_scale #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned Q     = 8380417,
  parameter int unsigned N     = 256,
  parameter int unsigned N_INV = 8347681
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [$clog2(N)-1:0] out_index,
  output logic                 out_last,
  output logic                 err_range
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned PW = 2 * WIDTH;

  logic             v1_q, v2_q, v3_q;
  logic [WIDTH-1:0] s1_q;
  logic [PW-1:0]    s2_q;
  logic [WIDTH-1:0] s3_q;
  logic [IW-1:0]    idx_q;
  logic             err_q;

  logic             stall;
  logic             accept;
  logic             xfer;
  logic [PW-1:0]    prod_d;
  logic [WIDTH-1:0] red_d;

  always_comb begin
    stall  = v3_q && !out_ready;
    accept = in_valid && !stall;
    xfer   = v3_q && out_ready;
    prod_d = PW'(s1_q) * PW'(N_INV);
    // exact remainder of the full product, so out-of-range inputs still reduce below Q
    red_d  = WIDTH'(s2_q % PW'(Q));
  end

  assign in_ready  = !stall;
  assign out_valid = v3_q;
  assign out_data  = s3_q;
  assign out_index = idx_q;
  assign out_last  = v3_q && (idx_q == IW'(N - 1));
  assign err_range = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      s3_q  <= '0;
      idx_q <= '0;
      err_q <= 1'b0;
    end else if (clear) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      idx_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (accept && (in_data >= WIDTH'(Q))) begin
        err_q <= 1'b1;
      end
      if (!stall) begin
        v1_q <= accept;
        v2_q <= v1_q;
        v3_q <= v2_q;
        s3_q <= red_d;
      end
      // N is a power of two, so the natural counter overflow is the frame wrap
      if (xfer) begin
        idx_q <= idx_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      s1_q <= in_data;
      s2_q <= prod_d;
    end
  end

endmodule

// File: tb/tb_intt_final_scale.sv
// Scoreboard bench for intt_final_scale: the driver queues expected outputs,
// a negedge monitor pops and compares on every output transfer.
module tb_intt_final_scale;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_index;
  logic        out_last;
  logic        err_range;

  intt_final_scale #(
    .WIDTH(32),
    .Q(8380417),
    .N(256),
    .N_INV(8347681)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clear(clear),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_index(out_index),
    .out_last(out_last),
    .err_range(err_range)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  idx;
    logic        last;
    int          acc;
    bit          chk_lat;
  } exp_t;

  exp_t   sb[$];
  exp_t   me;
  int     n_tests = 0;
  int     n_fail  = 0;
  int     cyc     = 0;
  int     exp_idx = 0;
  bit     bp      = 0;
  int     pcnt    = 0;
  bit     held    = 0;
  longint snap;

  localparam logic [31:0] QV = 32'd8380417;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string nm, longint act, longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] model(longint unsigned d);
    return 32'((d * 64'd8347681) % 64'd8380417);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      held = 0;
    end else begin
      check("in_ready", longint'(in_ready), longint'(!(out_valid && !out_ready)));
      if (held && out_valid)
        check("stall_hold", {out_data, out_index, out_last}, snap);
      if (!clear && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out: got data %0d index %0d expected no output", out_data, out_index);
        end else begin
          me = sb.pop_front();
          check("out_data", longint'(out_data), longint'(me.data));
          check("out_index", longint'(out_index), longint'(me.idx));
          check("out_last", longint'(out_last), longint'(me.last));
          if (me.chk_lat) check("latency", longint'(cyc - me.acc), 3);
        end
      end
      held = out_valid && !out_ready && !clear;
      snap = {out_data, out_index, out_last};
    end
  end

  // One clock cycle of drive; entered and left at posedge+1.
  task automatic step(input bit v, input logic [31:0] d, input bit ordy,
                      input logic [31:0] ev, input bit lat, output bit acc);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    @(negedge clk);
    acc = v && in_ready;
    if (acc) begin
      sb.push_back('{ev, 8'(exp_idx), exp_idx == 255, cyc, lat});
      exp_idx = (exp_idx + 1) % 256;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic [31:0] ev, input bit lat, output int tries);
    bit a;
    a = 0;
    tries = 0;
    while (!a && tries < 30) begin
      step(1'b1, d, bp ? (pcnt % 3 == 0) : 1'b1, ev, lat, a);
      pcnt++;
      tries++;
    end
    if (!a) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got no accept expected accept of %0d", d);
    end
  endtask

  task automatic drain();
    int k;
    bit a;
    k  = 0;
    bp = 0;
    while ((sb.size() != 0 || out_valid) && k < 40) begin
      step(1'b0, 32'd0, 1'b1, 32'd0, 1'b0, a);
      k++;
    end
    check("drain_pending", longint'(sb.size()), 0);
  endtask

  task automatic do_clear(input bit v);
    in_valid  = v;
    in_data   = 32'd123;
    out_ready = 1'b1;
    clear     = 1'b1;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    exp_idx = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int tries;
  int total;
  bit a;

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #22;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_last", longint'(out_last), 0);
    check("rst_out_index", longint'(out_index), 0);
    check("rst_err_range", longint'(err_range), 0);
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_out_data", longint'(out_data), 0);

    // single hand-computed values
    send(32'd1, 32'd8347681, 1'b1, tries);       drain();
    send(32'd256, 32'd1, 1'b1, tries);           drain();
    send(32'd8380416, 32'd32736, 1'b1, tries);   drain();
    send(32'd0, 32'd0, 1'b1, tries);             drain();
    check("single_err_range", longint'(err_range), 0);

    // full frame plus wrap
    do_clear(1'b0);
    total = 0;
    for (int i = 0; i < 257; i++) begin
      send(32'(i), model(longint'(i)), 1'b0, tries);
      total += tries;
    end
    check("frame_no_bubbles", longint'(total), 257);
    drain();

    // backpressure 1-high/2-low
    bp = 1;
    pcnt = 0;
    for (int i = 0; i < 10; i++) send(32'(i * 1000 + 17), model(longint'(i * 1000 + 17)), 1'b0, tries);
    drain();

    // range flag
    send(QV, 32'd0, 1'b0, tries);
    check("err_set", longint'(err_range), 1);
    send(32'd2, 32'd8314945, 1'b0, tries);
    send(32'd3, 32'd8282209, 1'b0, tries);
    drain();
    check("err_sticky", longint'(err_range), 1);
    do_clear(1'b0);
    check("err_cleared", longint'(err_range), 0);

    // clear mid-frame with a coincident input
    for (int i = 0; i < 100; i++) send(32'(i + 5000), model(longint'(i + 5000)), 1'b0, tries);
    do_clear(1'b1);
    check("clear_out_valid", longint'(out_valid), 0);
    send(32'd256, 32'd1, 1'b1, tries);
    drain();

    // asynchronous reset while a last, out-of-range sample is stalled at the output
    do_clear(1'b0);
    for (int i = 0; i < 255; i++) send(32'(i + 300), model(longint'(i + 300)), 1'b0, tries);
    drain();
    step(1'b1, QV, 1'b1, 32'd0, 1'b0, a);
    for (int k = 0; k < 10 && !out_valid; k++) step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, a);
    check("pre_rst_out_valid", longint'(out_valid), 1);
    check("pre_rst_out_last", longint'(out_last), 1);
    check("pre_rst_err_range", longint'(err_range), 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", longint'(out_valid), 0);
    check("arst_out_last", longint'(out_last), 0);
    check("arst_err_range", longint'(err_range), 0);
    check("arst_in_ready", longint'(in_ready), 1);
    check("arst_out_index", longint'(out_index), 0);
    sb.delete();
    exp_idx = 0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_out_data", longint'(out_data), 0);
    for (int k = 0; k < 5; k++) step(1'b0, 32'd0, 1'b1, 32'd0, 1'b0, a);
    check("post_rst_idle", longint'(out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
